// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock, LSB slice first.
// Latency: start accepted at edge E -> done pulses after edge E+NSTEPS; one result per NSTEPS+1 cycles.
// Handshake: start is sampled only when busy=0; diff/bout/ovf hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSTEPS = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept, step, last;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] slice_d;
  logic             slice_b;
  logic             msb_bin;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake decode; start is only looked at when not running.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CW'(NSTEPS - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One slice of subtraction; the extra top bit of the DIGIT+1 wide result is the borrow out.
  always_comb begin
    {slice_b, slice_d} = {1'b0, op_a[DIGIT-1:0]} - {1'b0, op_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    acc_nxt            = (acc >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
  end

  // Borrow into the MSB: only meaningful on the last slice, where op_a/op_b hold the top bits.
  generate
    if (DIGIT == 1) begin : g_msb_single
      assign msb_bin = borrow;
    end else begin : g_msb_multi
      assign msb_bin = (op_a[DIGIT-2:0] < op_b[DIGIT-2:0]) ||
                       ((op_a[DIGIT-2:0] == op_b[DIGIT-2:0]) && borrow);
    end
  endgenerate

  // Operand/partial-result shifting and result capture on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= b;
      acc    <= '0;
      borrow <= bin;
      cnt    <= '0;
    end else if (step) begin
      op_a   <= op_a >> DIGIT;
      op_b   <= op_b >> DIGIT;
      acc    <= acc_nxt;
      borrow <= slice_b;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= acc_nxt;
        bout <= slice_b;
        ovf  <= msb_bin ^ slice_b;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench: five configurations (8/2, 8/8, 16/4, 12/3, 1/1) share one stimulus stream.
// Each has a transaction-level model (accept when idle, result lands NSTEPS edges later).
// Outputs are compared every negedge; directed cases pin the model with literal values.
module tb_serial_subtractor;

  localparam int NCFG = 5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_s, b_s;
  logic        bin_s;

  logic [NCFG-1:0]       busy_w, done_w, bout_w, ovf_w;
  logic [NCFG-1:0][15:0] diff_w;
  logic [NCFG-1:0]       mbusy_w, mdone_w, mbout_w, movf_w;
  logic [NCFG-1:0][15:0] mdiff_w;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 16 : (g == 3) ? 12 : 1;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 8 : (g == 2) ? 4  : (g == 3) ? 3  : 1;
    localparam int NS = W / D;

    logic         d_busy, d_done, d_bout, d_ovf;
    logic [W-1:0] d_diff;

    serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a_s[W-1:0]),
      .b     (b_s[W-1:0]),
      .bin   (bin_s),
      .busy  (d_busy),
      .done  (d_done),
      .diff  (d_diff),
      .bout  (d_bout),
      .ovf   (d_ovf)
    );

    // Returns {bout, diff, ovf} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] u;
      longint     sx, sy, sv;
      logic       o;
      u  = {1'b0, x} - {1'b0, y} - (W+1)'(c);
      sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
      sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
      sv = sx - sy - longint'(c);
      o  = (sv < -(longint'(1) << (W-1))) || (sv > ((longint'(1) << (W-1)) - 1));
      return {u[W], u[W-1:0], o};
    endfunction

    logic [W-1:0] m_diff, p_diff;
    logic         m_bout, m_ovf, m_done, p_bout, p_ovf;
    int           m_cnt;

    // Transaction model: a request is taken when nothing is in flight; NS edges later the
    // pending result becomes visible for one done cycle and is then held.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_cnt  <= 0;
        m_done <= 1'b0;
        m_diff <= '0;
        m_bout <= 1'b0;
        m_ovf  <= 1'b0;
        p_diff <= '0;
        p_bout <= 1'b0;
        p_ovf  <= 1'b0;
      end else begin
        m_done <= 1'b0;
        if (m_cnt != 0) begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_diff <= p_diff;
            m_bout <= p_bout;
            m_ovf  <= p_ovf;
            m_done <= 1'b1;
          end
        end else if (start) begin
          {p_bout, p_diff, p_ovf} <= ref_sub(a_s[W-1:0], b_s[W-1:0], bin_s);
          m_cnt <= NS;
        end
      end
    end

    assign busy_w[g]  = d_busy;
    assign done_w[g]  = d_done;
    assign bout_w[g]  = d_bout;
    assign ovf_w[g]   = d_ovf;
    assign diff_w[g]  = 16'(d_diff);
    assign mbusy_w[g] = (m_cnt != 0);
    assign mdone_w[g] = m_done;
    assign mbout_w[g] = m_bout;
    assign movf_w[g]  = m_ovf;
    assign mdiff_w[g] = 16'(m_diff);
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("cfg%0d busy", g), 16'(busy_w[g]), 16'(mbusy_w[g]));
      chk($sformatf("cfg%0d done", g), 16'(done_w[g]), 16'(mdone_w[g]));
      chk($sformatf("cfg%0d diff", g), diff_w[g],      mdiff_w[g]);
      chk($sformatf("cfg%0d bout", g), 16'(bout_w[g]), 16'(mbout_w[g]));
      chk($sformatf("cfg%0d ovf",  g), 16'(ovf_w[g]),  16'(movf_w[g]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Issue one request and wait for config g's done; check latency and literal results.
  task automatic run_op(input int g, input logic [15:0] aa, input logic [15:0] bb, input logic cc,
                        input int exp_lat, input logic [15:0] ed, input logic eb, input logic eo,
                        input string nm);
    int  n;
    bit  got;
    start = 1'b1;
    a_s   = aa;
    b_s   = bb;
    bin_s = cc;
    tick();
    start = 1'b0;
    n     = 1;
    got   = 1'b0;
    while (!got && n < 40) begin
      if (done_w[g]) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk({nm, " latency"}, 16'(n), 16'(exp_lat));
    chk({nm, " diff"}, diff_w[g], ed);
    chk({nm, " bout"}, 16'(bout_w[g]), 16'(eb));
    chk({nm, " ovf"},  16'(ovf_w[g]),  16'(eo));
  endtask

  initial begin
    int          ndone;
    int          comp [NCFG];
    logic [2:0]  v;
    logic        ed, eb;

    rst_n = 1'b1;
    start = 1'b0;
    a_s   = '0;
    b_s   = '0;
    bin_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("reset cfg%0d busy", g), 16'(busy_w[g]), 16'h0);
      chk($sformatf("reset cfg%0d done", g), 16'(done_w[g]), 16'h0);
      chk($sformatf("reset cfg%0d diff", g), diff_w[g], 16'h0);
      chk($sformatf("reset cfg%0d bout", g), 16'(bout_w[g]), 16'h0);
      chk($sformatf("reset cfg%0d ovf",  g), 16'(ovf_w[g]), 16'h0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed 8/2 cases.
    run_op(0, 16'h0005, 16'h0003, 1'b0, 5, 16'h0002, 1'b0, 1'b0, "5-3");
    run_op(0, 16'h0000, 16'h0001, 1'b0, 5, 16'h00FF, 1'b1, 1'b0, "0-1");
    run_op(0, 16'h0080, 16'h0001, 1'b0, 5, 16'h007F, 1'b0, 1'b1, "80-1");

    // Abort two cycles into an operation: outputs clear at once, no done afterwards.
    start = 1'b1;
    a_s   = 16'h0033;
    b_s   = 16'h0011;
    bin_s = 1'b0;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 16'(busy_w), 16'h0);
    chk("abort done", 16'(done_w), 16'h0);
    chk("abort diff8", diff_w[0], 16'h0);
    chk("abort bout", 16'(bout_w), 16'h0);
    chk("abort ovf",  16'(ovf_w),  16'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort no done", 16'(done_w), 16'h0);
    end
    run_op(0, 16'h0009, 16'h0004, 1'b0, 5, 16'h0005, 1'b0, 1'b0, "9-4");
    run_op(0, 16'h0010, 16'h000F, 1'b1, 5, 16'h0000, 1'b0, 1'b0, "10-F-1");

    // Start held high: one completion per five cycles on the 8/2 unit.
    ndone = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a_s   = 16'($urandom);
      b_s   = 16'($urandom);
      bin_s = 1'($urandom);
      tick();
      if (done_w[0]) ndone++;
    end
    start = 1'b0;
    chk("held start dones", 16'(ndone), 16'd6);
    tick();
    tick();

    // Single-step configuration.
    run_op(1, 16'h0037, 16'h0040, 1'b1, 2, 16'h00F6, 1'b1, 1'b0, "8/8 37-40-1");

    // One-bit configuration against the full-subtractor truth table.
    for (int i = 0; i < 8; i++) begin
      v  = i[2:0];
      ed = v[2] ^ v[1] ^ v[0];
      eb = (~v[2] & v[1]) | (~(v[2] ^ v[1]) & v[0]);
      tick();
      run_op(4, {15'b0, v[2]}, {15'b0, v[1]}, v[0], 2, {15'b0, ed}, eb, v[0] ^ eb,
             $sformatf("fs a%0d b%0d c%0d", v[2], v[1], v[0]));
    end
    tick();
    tick();

    // Random traffic, mostly back-to-back, with occasional extreme operands.
    for (int g = 0; g < NCFG; g++) comp[g] = 0;
    for (int i = 0; i < 7000; i++) begin
      start = ($urandom_range(0, 15) != 0);
      a_s   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b_s   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b_s = 16'hFFFF;
      bin_s = 1'($urandom);
      tick();
      for (int g = 0; g < NCFG; g++) if (done_w[g]) comp[g]++;
    end
    start = 1'b0;
    for (int g = 0; g < 4; g++)
      chk($sformatf("cfg%0d enough completions", g), 16'(comp[g] >= 1000), 16'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
